// File: rtl/qnigma_mdio_arb.sv
// Round-robin arbiter sharing one MDIO serial engine among N_REQ requesters.
// Latches the winner's command, issues one send, returns data/ack/err.
module qnigma_mdio_arb #(
  parameter int N_REQ       = 2,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ-1:0]     req_r_nw,
  input  logic [N_REQ*5-1:0]   req_phyad,
  input  logic [N_REQ*5-1:0]   req_regad,
  input  logic [N_REQ*16-1:0]  req_wdat,
  output logic [N_REQ-1:0]     gnt,
  output logic [N_REQ-1:0]     ack,
  output logic                 err,
  output logic [15:0]          rdat,
  output logic                 eng_r_nw,
  output logic [4:0]           eng_phyad,
  output logic [4:0]           eng_regad,
  output logic [15:0]          eng_wdat,
  output logic                 eng_send,
  input  logic                 eng_ready,
  input  logic                 eng_done,
  input  logic                 eng_val,
  input  logic [15:0]          eng_dat,
  input  logic [4:0]           eng_adr,
  output logic                 busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t           r_st;
  state_t           w_nx;
  logic [IW-1:0]    r_last;
  logic [IW-1:0]    w_win;
  logic             w_hi;
  logic             w_any;
  logic             w_rnw;
  logic [4:0]       w_phy;
  logic [4:0]       w_reg;
  logic [15:0]      w_wd;
  logic [N_REQ-1:0] r_gnt;
  logic             r_rnw;
  logic [4:0]       r_phy;
  logic [4:0]       r_reg;
  logic [15:0]      r_wd;
  logic [CW-1:0]    r_cnt;
  logic             r_to;
  logic             r_cap;
  logic [15:0]      r_cdat;
  logic [15:0]      r_rdat;
  logic             w_tmo;

  // Lowest set bit above r_last wins, else lowest set bit overall.
  always_comb begin
    w_win = r_last;
    w_hi  = 1'b0;
    w_any = |req;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i] && (IW'(i) > r_last)) begin
        w_win = IW'(i);
        w_hi  = 1'b1;
      end
    end
    if (!w_hi) begin
      for (int i = N_REQ - 1; i >= 0; i--) begin
        if (req[i]) w_win = IW'(i);
      end
    end
  end

  always_comb begin
    w_rnw = 1'b0;
    w_phy = '0;
    w_reg = '0;
    w_wd  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_win == IW'(i)) begin
        w_rnw = req_r_nw[i];
        w_phy = req_phyad[5*i +: 5];
        w_reg = req_regad[5*i +: 5];
        w_wd  = req_wdat[16*i +: 16];
      end
    end
  end

  // r_cnt counts cycles since the send pulse.
  assign w_tmo = (TIMEOUT_CYC > 0) &&
                 (r_cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (!rstn) r_st <= S_IDLE;
    else       r_st <= w_nx;
  end

  always_comb begin
    w_nx = r_st;
    unique case (r_st)
      S_IDLE:  if (w_any && eng_ready) w_nx = S_ISSUE;
      S_ISSUE: w_nx = S_WAIT;
      S_WAIT:  if (eng_done || w_tmo) w_nx = S_RESP;
      S_RESP:  w_nx = S_IDLE;
      default: w_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_last <= IW'(N_REQ - 1);
      r_gnt  <= '0;
      r_rnw  <= 1'b0;
      r_phy  <= '0;
      r_reg  <= '0;
      r_wd   <= '0;
      r_cnt  <= '0;
      r_to   <= 1'b0;
      r_cap  <= 1'b0;
      r_cdat <= '0;
      r_rdat <= '0;
    end else begin
      unique case (r_st)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_nx == S_ISSUE) begin
            r_gnt  <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
            r_last <= w_win;
            r_rnw  <= w_rnw;
            r_phy  <= w_phy;
            r_reg  <= w_reg;
            r_wd   <= w_wd;
            r_cap  <= 1'b0;
            r_to   <= 1'b0;
          end
        end
        S_ISSUE: begin
          if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
        end
        S_WAIT: begin
          if (r_cnt != '1) r_cnt <= r_cnt + CW'(1);
          if (eng_val && (eng_adr == r_reg)) begin
            r_cdat <= eng_dat;
            r_cap  <= 1'b1;
          end
          if (!eng_done && w_tmo) r_to <= 1'b1;
        end
        S_RESP: begin
          r_gnt <= '0;
          if (r_rnw && r_cap) r_rdat <= r_cdat;
        end
        default: ;
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign ack       = r_gnt & {N_REQ{r_st == S_RESP}};
  assign err       = (r_st == S_RESP) && (r_to || (r_rnw && !r_cap));
  assign rdat      = ((r_st == S_RESP) && r_rnw && r_cap) ? r_cdat : r_rdat;
  assign eng_r_nw  = r_rnw;
  assign eng_phyad = r_phy;
  assign eng_regad = r_reg;
  assign eng_wdat  = r_wd;
  assign eng_send  = (r_st == S_ISSUE);
  assign busy      = (r_st != S_IDLE);

endmodule

// File: tb/tb_qnigma_mdio_arb.sv
// Bench for qnigma_mdio_arb: directed literal cases plus random traffic
// compared every cycle against a transaction-timeline model.
module tb_qnigma_mdio_arb;

  localparam int N   = 2;
  localparam int TMO = 100;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_r_nw = '0;
  logic [N*5-1:0]  req_phyad = '0;
  logic [N*5-1:0]  req_regad = '0;
  logic [N*16-1:0] req_wdat = '0;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic            err;
  logic [15:0]     rdat;
  logic            eng_r_nw;
  logic [4:0]      eng_phyad;
  logic [4:0]      eng_regad;
  logic [15:0]     eng_wdat;
  logic            eng_send;
  logic            eng_ready = 1'b0;
  logic            eng_done = 1'b0;
  logic            eng_val = 1'b0;
  logic [15:0]     eng_dat = '0;
  logic [4:0]      eng_adr = '0;
  logic            busy;

  int n_tot = 0;
  int n_bad = 0;
  int cyc = 0;

  qnigma_mdio_arb #(.N_REQ(N), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstn(rstn), .req(req), .req_r_nw(req_r_nw),
    .req_phyad(req_phyad), .req_regad(req_regad), .req_wdat(req_wdat),
    .gnt(gnt), .ack(ack), .err(err), .rdat(rdat),
    .eng_r_nw(eng_r_nw), .eng_phyad(eng_phyad), .eng_regad(eng_regad),
    .eng_wdat(eng_wdat), .eng_send(eng_send), .eng_ready(eng_ready),
    .eng_done(eng_done), .eng_val(eng_val), .eng_dat(eng_dat),
    .eng_adr(eng_adr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [63:0] a,
                     input logic [63:0] e);
    n_tot++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", nm, a, e, cyc);
    end
  endtask

  // Transaction model: t counts cycles since the send pulse.
  bit          mon_en = 0;
  int          m_own = -1;
  int          m_last = N - 1;
  int          m_t = 0;
  int          m_end = -1;
  bit          m_to, m_cap, m_rd;
  logic [4:0]  m_ph, m_rg;
  logic [15:0] m_wd, m_cd;
  logic [15:0] m_rdat = '0;
  logic [N-1:0] e_g, e_a;
  bit          e_e;
  logic [15:0] e_r;
  int          w;

  always begin
    @(negedge clk);
    if (mon_en) begin
      e_g = '0;
      if (m_own >= 0) e_g[m_own] = 1'b1;
      e_a = (m_own >= 0 && m_end == m_t) ? e_g : '0;
      e_e = (e_a != '0) && (m_to || (m_rd && !m_cap));
      e_r = (e_a != '0 && m_rd && m_cap) ? m_cd : m_rdat;
      chk("m_gnt", 64'(gnt), 64'(e_g));
      chk("m_ack", 64'(ack), 64'(e_a));
      chk("m_err", 64'(err), 64'(e_e));
      chk("m_rdat", 64'(rdat), 64'(e_r));
      chk("m_busy", 64'(busy), 64'(m_own >= 0));
      chk("m_send", 64'(eng_send), 64'(m_own >= 0 && m_t == 0));
      if (m_own >= 0)
        chk("m_cmd", 64'({eng_r_nw, eng_phyad, eng_regad, eng_wdat}),
            64'({m_rd, m_ph, m_rg, m_wd}));
    end
    @(posedge clk);
    if (!rstn) begin
      m_own = -1;
      m_last = N - 1;
      m_rdat = '0;
    end else if (m_own >= 0) begin
      if (m_end == m_t) begin
        if (m_rd && m_cap) m_rdat = m_cd;
        m_own = -1;
      end else begin
        if (m_t >= 1 && m_end < 0) begin
          if (eng_val && eng_adr == m_rg) begin
            m_cap = 1;
            m_cd = eng_dat;
          end
          if (eng_done) m_end = m_t + 1;
          else if (m_t + 1 == TMO) begin
            m_end = TMO;
            m_to = 1;
          end
        end
        m_t++;
      end
    end else if (req != '0 && eng_ready) begin
      w = -1;
      for (int k = 1; k <= N; k++)
        if (w < 0 && req[(m_last + k) % N]) w = (m_last + k) % N;
      m_own = w;
      m_last = w;
      m_rd = req_r_nw[w];
      m_ph = req_phyad[5*w +: 5];
      m_rg = req_regad[5*w +: 5];
      m_wd = req_wdat[16*w +: 16];
      m_t = 0;
      m_end = -1;
      m_to = 0;
      m_cap = 0;
    end
  end

  // Engine stand-in: plan chosen at each send, or forced by f_* fields.
  bit          noise_en = 0, rdy_rand = 0, f_valid = 0;
  int          f_d, f_vt, e_d, e_vt, e_t;
  logic [4:0]  f_adr, e_adr;
  logic [15:0] f_dat, e_dat;
  bit          e_busy = 0;

  always begin
    @(negedge clk);
    if (!rstn || ack != '0 || !busy) e_busy = 0;
    else if (e_busy && e_d != 0 && e_t >= e_d) e_busy = 0;
    if (rstn && eng_send) begin
      e_busy = 1;
      e_t = 0;
      if (f_valid) begin
        e_d = f_d; e_vt = f_vt; e_adr = f_adr; e_dat = f_dat;
        f_valid = 0;
      end else begin
        e_d = ($urandom_range(0, 19) == 0) ? 0 : $urandom_range(1, 12);
        e_vt = $urandom_range(0, (e_d == 0) ? 6 : e_d);
        e_adr = ($urandom_range(0, 3) == 0) ? 5'($urandom) : eng_regad;
        e_dat = 16'($urandom);
      end
    end else if (e_busy) e_t++;
    eng_done = e_busy && e_t > 0 && e_t == e_d;
    eng_val = e_busy && e_t > 0 && e_t == e_vt;
    eng_adr = e_adr;
    eng_dat = eng_val ? e_dat : 16'($urandom);
    if (!e_busy && noise_en) begin
      eng_done = ($urandom_range(0, 5) == 0);
      eng_val = ($urandom_range(0, 5) == 0);
      eng_adr = eng_regad;
    end
    eng_ready = !e_busy && (!rdy_rand || $urandom_range(0, 3) != 0);
  end

  task automatic plan(input int d, input int vt, input logic [4:0] a,
                      input logic [15:0] dat);
    f_d = d; f_vt = vt; f_adr = a; f_dat = dat; f_valid = 1;
  endtask

  task automatic set_cmd(input int i, input bit rnw, input logic [4:0] ph,
                         input logic [4:0] rg, input logic [15:0] wd);
    req_r_nw[i] = rnw;
    req_phyad[5*i +: 5] = ph;
    req_regad[5*i +: 5] = rg;
    req_wdat[16*i +: 16] = wd;
  endtask

  task automatic wait_ev(input bit is_ack, output int at);
    at = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (is_ack ? (ack != '0) : (eng_send == 1'b1)) begin
        at = cyc;
        break;
      end
    end
    n_tot++;
    if (at < 0) begin
      n_bad++;
      $display("FAIL wait_%s act=timeout exp=event", is_ack ? "ack" : "send");
    end
  endtask

  int ts, ta;
  logic [N-1:0] g;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_ack", 64'(ack), 64'd0);
    chk("rst_flags", 64'({err, busy, eng_send}), 64'd0);
    chk("rst_rdat", 64'(rdat), 64'd0);
    chk("rst_cmd", 64'({eng_r_nw, eng_phyad, eng_regad, eng_wdat}), 64'd0);
    rstn = 1;
    mon_en = 1;

    plan(70, 0, 5'd0, 16'h0);
    set_cmd(0, 1'b0, 5'd1, 5'd0, 16'h1200);
    req = 2'b01;
    wait_ev(0, ts);
    chk("wr_cmd", 64'({eng_r_nw, eng_phyad, eng_regad, eng_wdat}),
        64'({1'b0, 5'd1, 5'd0, 16'h1200}));
    chk("wr_gnt", 64'(gnt), 64'd1);
    wait_ev(1, ta);
    chk("wr_lat", 64'(ta - ts), 64'd71);
    chk("wr_ack", 64'({ack, err}), 64'({2'b01, 1'b0}));
    chk("wr_rdat", 64'(rdat), 64'd0);
    req = '0;

    plan(10, 5, 5'd2, 16'h0141);
    set_cmd(1, 1'b1, 5'd3, 5'd2, 16'h0);
    req = 2'b10;
    wait_ev(1, ta);
    chk("rd_ack", 64'({ack, err}), 64'({2'b10, 1'b0}));
    chk("rd_rdat", 64'(rdat), 64'h0141);
    req = '0;

    plan(0, 0, 5'd0, 16'h0);
    set_cmd(0, 1'b0, 5'd4, 5'd7, 16'hAAAA);
    req = 2'b01;
    wait_ev(0, ts);
    wait_ev(1, ta);
    chk("to_lat", 64'(ta - ts), 64'd100);
    chk("to_err", 64'({ack, err}), 64'({2'b01, 1'b1}));
    chk("to_rdat", 64'(rdat), 64'h0141);
    req = '0;
    plan(5, 5, 5'd3, 16'hBEEF);
    set_cmd(0, 1'b1, 5'd4, 5'd3, 16'h0);
    req = 2'b01;
    wait_ev(1, ta);
    chk("after_to", 64'({ack, err, rdat}), 64'({2'b01, 1'b0, 16'hBEEF}));
    req = '0;

    plan(8, 4, 5'd5, 16'h1234);
    set_cmd(1, 1'b1, 5'd3, 5'd2, 16'h0);
    req = 2'b10;
    wait_ev(1, ta);
    chk("mis_err", 64'({ack, err}), 64'({2'b10, 1'b1}));
    chk("mis_rdat", 64'(rdat), 64'hBEEF);
    req = '0;

    set_cmd(0, 1'b0, 5'd1, 5'd1, 16'h0011);
    set_cmd(1, 1'b0, 5'd2, 5'd2, 16'h0022);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_ev(0, ts);
      g = gnt;
      chk($sformatf("rr_%0d", k), 64'(g), (k % 2 == 0) ? 64'd1 : 64'd2);
    end
    wait_ev(1, ta);
    req = '0;

    plan(50, 0, 5'd0, 16'h0);
    set_cmd(0, 1'b0, 5'd9, 5'd9, 16'h0909);
    req = 2'b01;
    wait_ev(0, ts);
    repeat (5) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    chk("mid_rst", 64'({gnt, ack, busy}), 64'd0);
    chk("mid_rst_rdat", 64'(rdat), 64'd0);
    rstn = 1;
    req = 2'b10;
    wait_ev(0, ts);
    chk("rst_g1", 64'(gnt), 64'd2);
    wait_ev(1, ta);
    req = '0;
    rstn = 0;
    @(negedge clk);
    rstn = 1;
    req = 2'b11;
    wait_ev(0, ts);
    chk("rst_g0", 64'(gnt), 64'd1);
    wait_ev(1, ta);
    req = '0;

    noise_en = 1;
    rdy_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rstn = (c != 1500);
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (ack[i]) begin
            if ($urandom_range(0, 1) == 0) req[i] = 1'b0;
            else set_cmd(i, 1'($urandom), 5'($urandom), 5'($urandom),
                         16'($urandom));
          end else if (gnt[i] && $urandom_range(0, 7) == 0)
            set_cmd(i, 1'($urandom), 5'($urandom), 5'($urandom),
                    16'($urandom));
          else if (gnt[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          set_cmd(i, 1'($urandom), 5'($urandom), 5'($urandom),
                  16'($urandom));
          req[i] = 1'b1;
        end
      end
    end
    @(negedge clk);
    rstn = 1;
    req = '0;
    noise_en = 0;
    repeat (150) @(negedge clk);
    mon_en = 0;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/qnigma_mdio_arb.md
Name: qnigma_mdio_arb

Overview:
- Round-robin arbiter and sequencer that shares one MDIO serial engine among N_REQ requesters (e.g. the link-poll controller and a host register-access port).
- Latches the winning requester's command, issues a single send to the engine and waits for done.
- Returns read data, an ack and an error flag to the owning requester.
- Sits between the requesters and the MDIO serial engine, with one engine per PHY management bus.

Parameters:
- N_REQ, 2, number of requesters (2..8).
- TIMEOUT_CYC, 0, maximum clk cycles from send to done; 0 disables the timeout.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- req  in  N_REQ  per-requester request level; held with its fields until ack.
- req_r_nw  in  N_REQ  1 = read, 0 = write.
- req_phyad  in  N_REQ*5  PHY address, requester i at bits [5i+4:5i].
- req_regad  in  N_REQ*5  register address, same packing as req_phyad.
- req_wdat  in  N_REQ*16  write data, requester i at bits [16i+15:16i].
- gnt  out  N_REQ  one-hot owner indication.
- ack  out  N_REQ  one-cycle completion pulse to the owner.
- err  out  1  valid with ack; 1 = timeout, or read finished without valid data.
- rdat  out  16  read data; valid with ack; holds its value until the next ack.
- eng_r_nw  out  1  to engine.
- eng_phyad  out  5  to engine.
- eng_regad  out  5  to engine.
- eng_wdat  out  16  to engine.
- eng_send  out  1  one-cycle start pulse to engine.
- eng_ready  in  1  engine idle and able to accept send.
- eng_done  in  1  engine completion pulse.
- eng_val  in  1  engine read-data valid strobe.
- eng_dat  in  16  engine read data.
- eng_adr  in  5  register address of the returned read data.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (rstn=0 at a rising clk):
  - FSM goes to IDLE.
  - gnt, ack, err, eng_send and busy = 0; rdat = 0; eng_* command outputs = 0.
  - Round-robin pointer last = N_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction abandons it silently: no ack is issued. The engine is reset by the same system; the arbiter does not drive it during reset.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req bit is set and eng_ready=1, select the first set bit searching upward from last+1, wrapping modulo N_REQ.
  - Set gnt one-hot and last = winner.
  - Latch the winner's r_nw, phyad, regad and wdat into the eng_* outputs.
  - Clear the capture flag. Go to ISSUE.
  - If eng_ready=0, stay in IDLE with no grant.
- ISSUE: eng_send=1 for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - If eng_val=1 and eng_adr equals the latched regad, capture eng_dat and set the capture flag. If eng_val and eng_done arrive in the same cycle, the capture counts.
  - On eng_done=1, go to RESP.
  - If TIMEOUT_CYC>0 and the counter reaches TIMEOUT_CYC-1 without eng_done, go to RESP with the timeout flag set.
- RESP:
  - ack[winner]=1 for one cycle.
  - err = timeout OR (read AND capture flag clear).
  - rdat = captured data for reads; rdat is unchanged for writes.
  - gnt clears at the end of the cycle; go to IDLE.
  - Minimum spacing between consecutive sends is 4 cycles.
- gnt is asserted from the IDLE->ISSUE edge through the RESP cycle inclusive.
- Commands are latched at grant, so requester fields may change after grant without effect.
- If req drops after grant, the transaction still completes and ack still pulses; the requester ignores it.
- New req edges while busy are not lost: req is a level and is re-evaluated in IDLE.
- Simultaneous requests: round-robin order guarantees no requester waits more than N_REQ-1 transactions.
- eng_done or eng_val seen in IDLE, ISSUE or RESP is ignored.
- The timeout counter is wide enough to hold TIMEOUT_CYC and saturates; it never wraps.

Test Plan:
- Single write: req[0]=1, write, phyad=1, regad=0, wdat=16'h1200; engine returns done 70 cycles after send -> one eng_send with the latched fields; ack[0] one cycle after done; err=0; rdat unchanged.
- Single read: req[1]=1, read, regad=2; engine gives eng_val with eng_adr=2, eng_dat=16'h0141, then done -> ack[1], rdat=16'h0141, err=0.
- Contention: req=2'b11 held continuously, N_REQ=2 -> grants alternate 0,1,0,1; exactly one eng_send per ack; gnt never has two bits set.
- Timeout: TIMEOUT_CYC=100, engine never asserts done -> ack exactly 100 cycles after eng_send, err=1; the next request is served normally.
- Read with mismatched eng_adr (5 vs latched 2), then done -> ack with err=1 and rdat unchanged.
- Reset mid-WAIT: rstn=0 for one cycle -> gnt=0, busy=0, no ack; then req[1]=1 is granted first only if req[0]=0, and req[0] wins if both are set.
